vga_sync_gen: RTL and testbench

//   Generates 640x480@60 VGA timing: free-running column/row counters, HSync/VSync pulses and a frame-start strobe.

---
 rtl/vga_sync_gen.sv | 157 +++++++++++++++
 tb/tb_vga_sync_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: column/row counters, frame-start strobe, and sync/active
// flags delayed so that they line up with the RGB that downstream tile logic returns.
module vga_sync_gen #(
    parameter int TOTAL_COLS    = 800,
    parameter int TOTAL_ROWS    = 525,
    parameter int ACTIVE_COLS   = 640,
    parameter int ACTIVE_ROWS   = 480,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_WIDTH  = 96,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_WIDTH  = 2,
    parameter int VIDEO_DELAY   = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Enable,
    input  logic [3:0] i_Red_Video,
    input  logic [3:0] i_Grn_Video,
    input  logic [3:0] i_Blu_Video,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Frame_Start,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic       o_Active,
    output logic [3:0] o_Red_Video,
    output logic [3:0] o_Grn_Video,
    output logic [3:0] o_Blu_Video
);

    generate
        if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) begin : g_bad_h_timing
            $error("vga_sync_gen: horizontal active+porch+sync exceeds TOTAL_COLS");
        end
        if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) begin : g_bad_v_timing
            $error("vga_sync_gen: vertical active+porch+sync exceeds TOTAL_ROWS");
        end
        if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024) begin : g_bad_total
            $error("vga_sync_gen: TOTAL_COLS/TOTAL_ROWS must fit 10-bit counters");
        end
        if (VIDEO_DELAY < 1 || VIDEO_DELAY > 4) begin : g_bad_delay
            $error("vga_sync_gen: VIDEO_DELAY must be 1..4");
        end
    endgenerate

    localparam logic [9:0]  COL_LAST   = 10'(TOTAL_COLS - 1);
    localparam logic [9:0]  ROW_LAST   = 10'(TOTAL_ROWS - 1);
    // 11-bit bounds so a 1024-wide timing still compares correctly against 10-bit counters
    localparam logic [10:0] C_ACT      = 11'(ACTIVE_COLS);
    localparam logic [10:0] R_ACT      = 11'(ACTIVE_ROWS);
    localparam logic [10:0] C_HS_START = 11'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [10:0] C_HS_END   = 11'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [10:0] R_VS_START = 11'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [10:0] R_VS_END   = 11'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);
    localparam int          LAST       = VIDEO_DELAY - 1;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t     state_q;
    logic [9:0] col_q;
    logic [9:0] row_q;
    logic       frame_start_q;

    // IDLE spends one enabled edge announcing (0,0) before the counters start moving.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            frame_start_q <= 1'b0;
        end else if (!i_Enable) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            frame_start_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            state_q       <= ST_RUN;
            frame_start_q <= 1'b1;
        end else begin
            frame_start_q <= 1'b0;
            if (col_q == COL_LAST) begin
                col_q <= '0;
                if (row_q == ROW_LAST) begin
                    row_q         <= '0;
                    frame_start_q <= 1'b1;
                end else begin
                    row_q <= row_q + 10'd1;
                end
            end else begin
                col_q <= col_q + 10'd1;
            end
        end
    end

    assign o_Col_Count   = col_q;
    assign o_Row_Count   = row_q;
    assign o_Frame_Start = frame_start_q;

    logic run_en;
    logic raw_act;
    logic raw_hs_n;
    logic raw_vs_n;

    assign run_en = i_Enable && (state_q == ST_RUN);

    always_comb begin
        raw_act  = 1'b0;
        raw_hs_n = 1'b1;
        raw_vs_n = 1'b1;
        if (run_en) begin
            raw_act  = ({1'b0, col_q} < C_ACT) && ({1'b0, row_q} < R_ACT);
            raw_hs_n = !(({1'b0, col_q} >= C_HS_START) && ({1'b0, col_q} < C_HS_END));
            raw_vs_n = !(({1'b0, row_q} >= R_VS_START) && ({1'b0, row_q} < R_VS_END));
        end
    end

    logic [VIDEO_DELAY-1:0] act_pipe;
    logic [VIDEO_DELAY-1:0] hs_pipe;
    logic [VIDEO_DELAY-1:0] vs_pipe;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            act_pipe <= '0;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
        end else begin
            act_pipe[0] <= raw_act;
            hs_pipe[0]  <= raw_hs_n;
            vs_pipe[0]  <= raw_vs_n;
            for (int i = 1; i < VIDEO_DELAY; i++) begin
                act_pipe[i] <= act_pipe[i-1];
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
            end
        end
    end

    // Returned RGB belongs to the pixel now at the end of the pipe, so both register together.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_HSync     <= 1'b1;
            o_VSync     <= 1'b1;
            o_Active    <= 1'b0;
            o_Red_Video <= 4'h0;
            o_Grn_Video <= 4'h0;
            o_Blu_Video <= 4'h0;
        end else begin
            o_HSync     <= hs_pipe[LAST];
            o_VSync     <= vs_pipe[LAST];
            o_Active    <= act_pipe[LAST];
            o_Red_Video <= act_pipe[LAST] ? i_Red_Video : 4'h0;
            o_Grn_Video <= act_pipe[LAST] ? i_Grn_Video : 4'h0;
            o_Blu_Video <= act_pipe[LAST] ? i_Blu_Video : 4'h0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a reduced-timing instance checked cycle by cycle against a queue of
// expected outputs, plus a full 640x480 instance measured for its hand-computed line timing.
module tb_vga_sync_gen;

    // Reduced timing: hsync low at cols 14..16, vsync low at rows 7..8, 200-cycle frame
    localparam int TC  = 20;
    localparam int TR  = 10;
    localparam int AC  = 12;
    localparam int AR  = 6;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VD  = 2;
    localparam logic [2:0] IDLE_RAW = 3'b011;  // {act, hs_n, vs_n}

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] red, grn, blu;
    logic [3:0] z4;
    logic [9:0] col_cnt, row_cnt;
    logic       fs, hs, vs, act;
    logic [3:0] o_r, o_g, o_b;
    logic [9:0] f_col, f_row;
    logic       f_fs, f_hs, f_vs, f_act;
    logic [3:0] f_r, f_g, f_b;

    vga_sync_gen #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW),
        .VIDEO_DELAY(VD)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en),
        .i_Red_Video(red), .i_Grn_Video(grn), .i_Blu_Video(blu),
        .o_Col_Count(col_cnt), .o_Row_Count(row_cnt), .o_Frame_Start(fs),
        .o_HSync(hs), .o_VSync(vs), .o_Active(act),
        .o_Red_Video(o_r), .o_Grn_Video(o_g), .o_Blu_Video(o_b)
    );

    vga_sync_gen dut_full (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en),
        .i_Red_Video(z4), .i_Grn_Video(z4), .i_Blu_Video(z4),
        .o_Col_Count(f_col), .o_Row_Count(f_row), .o_Frame_Start(f_fs),
        .o_HSync(f_hs), .o_VSync(f_vs), .o_Active(f_act),
        .o_Red_Video(f_r), .o_Grn_Video(f_g), .o_Blu_Video(f_b)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [35:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // ---------------- reference model ----------------
    int          m_t;        // enabled edges since start; 0 = not running
    int          m_col, m_row;
    logic        m_fs;
    logic [2:0]  raw_q[$];
    logic [2:0]  m_out_raw;
    logic [11:0] m_vid;
    logic [9:0]  hc0, hc1, hc2, hr0, hr1, hr2;
    int          vid_mode;   // 0 zero, 1 all-F, 2 counter feedback

    function automatic logic [35:0] pack(input logic [9:0] c, input logic [9:0] r, input logic f,
                                         input logic h, input logic v, input logic a,
                                         input logic [11:0] rgb);
        return {c, r, f, h, v, a, rgb};
    endfunction

    function automatic logic [35:0] dut_vec();
        return pack(col_cnt, row_cnt, fs, hs, vs, act, {o_r, o_g, o_b});
    endfunction

    function automatic logic [35:0] idle_vec();
        return pack(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    endtask

    function automatic logic [2:0] model_raw();
        logic a, h, v;
        if (m_t == 0 || !en) return IDLE_RAW;
        a = (m_col < AC) && (m_row < AR);
        h = !((m_col >= AC + HFP) && (m_col < AC + HFP + HSW));
        v = !((m_row >= AR + VFP) && (m_row < AR + VFP + VSW));
        return {a, h, v};
    endfunction

    task automatic update_counts();
        int idx;
        if (m_t == 0) begin
            m_col = 0; m_row = 0; m_fs = 1'b0;
        end else begin
            idx   = (m_t - 1) % (TC * TR);
            m_col = idx % TC;
            m_row = idx / TC;
            m_fs  = (idx == 0);
        end
    endtask

    task automatic model_reset();
        m_t = 0;
        raw_q.delete();
        repeat (VD) raw_q.push_back(IDLE_RAW);
        m_out_raw = IDLE_RAW;
        m_vid     = 12'h000;
    endtask

    task automatic drive_video();
        case (vid_mode)
            1:       begin red = 4'hF; grn = 4'hF; blu = 4'hF; end
            2:       begin red = hc2[3:0]; grn = hr2[3:0]; blu = ~hc2[3:0]; end
            default: begin red = 4'h0; grn = 4'h0; blu = 4'h0; end
        endcase
    endtask

    // ---------------- driver: one clock edge plus the expectation it implies ----------------
    task automatic tick();
        logic [2:0]  raw;
        logic [11:0] vid;
        raw = model_raw();
        vid = {red, grn, blu};
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            raw_q.push_back(raw);
            m_out_raw = raw_q.pop_front();
            m_vid     = m_out_raw[2] ? vid : 12'h000;
            m_t       = en ? m_t + 1 : 0;
        end
        update_counts();
        #1;
        exp_q.push_back(pack(10'(m_col), 10'(m_row), m_fs, m_out_raw[1], m_out_raw[0],
                             m_out_raw[2], m_vid));
        hc2 = hc1; hc1 = hc0; hc0 = 10'(m_col);
        hr2 = hr1; hr1 = hr0; hr0 = 10'(m_row);
        drive_video();
    endtask

    task automatic run_to(input int c, input int r);
        int found;
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            if (m_col == c && m_row == r) found = 1;
            else tick();
        end
        check("run_to_position", 64'(found), 64'd1);
    endtask

    task automatic reset_pulse(input int cycles);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset_idle", 64'(dut_vec()), 64'(idle_vec()));
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) check("pixel", 64'(dut_vec()), 64'(exp_q.pop_front()));
    end

    // ---------------- directed measurements ----------------
    task automatic measure_full();
        int   cyc, fs_at, fall1, rise1, fall2;
        logic prev_hs;
        cyc = 0; fs_at = -1; fall1 = -1; rise1 = -1; fall2 = -1; prev_hs = 1'b1;
        while (cyc < 2000 && fall2 < 0) begin
            @(negedge clk);
            cyc++;
            if (f_fs && fs_at < 0) fs_at = cyc;
            if (fs_at >= 0) begin
                if (prev_hs && !f_hs) begin
                    if (fall1 < 0) fall1 = cyc;
                    else fall2 = cyc;
                end
                if (!prev_hs && f_hs && fall1 >= 0 && rise1 < 0) rise1 = cyc;
            end
            prev_hs = f_hs;
        end
        check("full_hsync_start_after_frame", 64'(fall1 - fs_at), 64'd659);
        check("full_hsync_low_width", 64'(rise1 - fall1), 64'd96);
        check("full_hsync_period", 64'(fall2 - fall1), 64'd800);
    endtask

    task automatic measure_small();
        int cyc, nfs, fs_prev, period, hs_lo, vs_lo, act_n, red_n;
        cyc = 0; nfs = 0; fs_prev = -1; period = -1;
        hs_lo = 0; vs_lo = 0; act_n = 0; red_n = 0;
        while (cyc < 1000 && nfs < 3) begin
            @(negedge clk);
            cyc++;
            if (fs) begin
                nfs++;
                if (nfs == 3) period = cyc - fs_prev;
                fs_prev = cyc;
            end
            if (nfs == 2) begin
                if (!hs) hs_lo++;
                if (!vs) vs_lo++;
                if (act) act_n++;
                if (o_r == 4'hF) red_n++;
            end
        end
        check("frame_start_period", 64'(period), 64'd200);
        check("hsync_low_per_frame", 64'(hs_lo), 64'd30);
        check("vsync_low_per_frame", 64'(vs_lo), 64'd40);
        check("active_per_frame", 64'(act_n), 64'd72);
        check("red_f_per_frame", 64'(red_n), 64'd72);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b1; en = 1'b0; z4 = 4'h0;
        red = 4'h0; grn = 4'h0; blu = 4'h0;
        hc0 = '0; hc1 = '0; hc2 = '0; hr0 = '0; hr1 = '0; hr2 = '0;
        vid_mode = 0;
        model_reset();
        update_counts();

        #2 rst_n = 1'b0;
        #1 check("async_reset_idle", 64'(dut_vec()), 64'(idle_vec()));
        en = 1'b1;
        repeat (20) tick();
        rst_n = 1'b1;

        fork
            measure_full();
            measure_small();
            begin
                vid_mode = 1;
                drive_video();
                repeat (800) tick();
                vid_mode = 2;
                drive_video();
                repeat (800) tick();
            end
        join

        run_to(5, 3);
        en = 1'b0;
        repeat (6) tick();
        en = 1'b1;
        repeat (30) tick();

        run_to(7, 2);
        reset_pulse(3);
        repeat (30) tick();

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
